// File: rtl/pipe_pkg.sv
// Shared definitions for the ID/EX, EX/MEM and MEM/WB pipeline register bank.
// Contents: default data/address widths, control bundle widths, bit positions
// of every control field, and the function that drops the execute-only fields
// (alu_op, alu_src, imm) when the decode bundle moves into the memory stage.
package pipe_pkg;

   localparam int PIPE_DATA_W = 16;
   localparam int PIPE_ADDR_W = 3;

   localparam int ID_CTRL_W  = 18;
   localparam int MEM_CTRL_W = 13;

   // decode control bundle
   localparam int ID_ALU_OP_HI    = 17;
   localparam int ID_ALU_OP_LO    = 15;
   localparam int ID_JUMP_HI      = 14;
   localparam int ID_JUMP_LO      = 12;
   localparam int ID_REG_WRITE    = 11;
   localparam int ID_ALU_SRC      = 10;
   localparam int ID_MEM_WRITE    = 9;
   localparam int ID_MEM_TO_REG   = 8;
   localparam int ID_MEM_READ     = 7;
   localparam int ID_BRANCH       = 6;
   localparam int ID_IN_PORT      = 5;
   localparam int ID_STACK_DATA   = 4;
   localparam int ID_PC_TO_STACK  = 3;
   localparam int ID_INC_DEC_SP   = 2;
   localparam int ID_IMM          = 1;
   localparam int ID_LDD_STD      = 0;

   // memory-stage control bundle
   localparam int MEM_JUMP_HI     = 12;
   localparam int MEM_JUMP_LO     = 10;
   localparam int MEM_REG_WRITE   = 9;
   localparam int MEM_MEM_WRITE   = 8;
   localparam int MEM_MEM_TO_REG  = 7;
   localparam int MEM_MEM_READ    = 6;
   localparam int MEM_BRANCH      = 5;
   localparam int MEM_IN_PORT     = 4;
   localparam int MEM_STACK_DATA  = 3;
   localparam int MEM_PC_TO_STACK = 2;
   localparam int MEM_INC_DEC_SP  = 1;
   localparam int MEM_LDD_STD     = 0;

   function automatic logic [MEM_CTRL_W-1:0] ex_to_mem_ctrl(input logic [ID_CTRL_W-1:0] c);
      logic [MEM_CTRL_W-1:0] m;
      m = '0;
      m[MEM_JUMP_HI:MEM_JUMP_LO] = c[ID_JUMP_HI:ID_JUMP_LO];
      m[MEM_REG_WRITE]           = c[ID_REG_WRITE];
      m[MEM_MEM_WRITE]           = c[ID_MEM_WRITE];
      m[MEM_MEM_TO_REG]          = c[ID_MEM_TO_REG];
      m[MEM_MEM_READ]            = c[ID_MEM_READ];
      m[MEM_BRANCH]              = c[ID_BRANCH];
      m[MEM_IN_PORT]             = c[ID_IN_PORT];
      m[MEM_STACK_DATA]          = c[ID_STACK_DATA];
      m[MEM_PC_TO_STACK]         = c[ID_PC_TO_STACK];
      m[MEM_INC_DEC_SP]          = c[ID_INC_DEC_SP];
      m[MEM_LDD_STD]             = c[ID_LDD_STD];
      return m;
   endfunction

endpackage

// File: rtl/pipe_reg.sv
// Generic W-bit pipeline register, loads every rising edge, synchronous
// active-high reset to zero.
// Ports: clk, reset, d [W-1:0] (next value), q [W-1:0] (registered value).
module pipe_reg #(
   parameter int W = 8
) (
   input  logic         clk,
   input  logic         reset,
   input  logic [W-1:0] d,
   output logic [W-1:0] q
);

   logic [W-1:0] r_q;

   always_ff @(posedge clk) begin
      if (reset) r_q <= '0;
      else       r_q <= d;
   end

   assign q = r_q;

endmodule

// File: rtl/pipe_regs_id_ex_mem_wb.sv
// ID/EX, EX/MEM and MEM/WB register bank of the 5-stage 16-bit processor.
// Every output comes straight from a flop; one cycle per stage, so an ID input
// reaches the WB outputs three edges later. reset clears all stages at once.
// Ports:
//   clk, reset                             clock, sync active-high clear
//   id_ctrl/id_rs_addr/id_rt_addr/
//   id_rd1/id_rd2/id_imm                   decode-stage inputs
//   ex_*                                   ID/EX register outputs
//   ex_alu_out                             ALU result into EX/MEM
//   mem_ctrl/mem_alu_out/mem_rd2/
//   mem_dst_addr                           EX/MEM register outputs
//   mem_data                               memory read data into MEM/WB
//   wb_*                                   MEM/WB register outputs
// Build option: define PIPE_FLUSH_EN to add input ex_flush, which turns the
// ID/EX control capture into a bubble while operands still load.
module pipe_regs_id_ex_mem_wb
   import pipe_pkg::*;
#(
   parameter int DATA_W = PIPE_DATA_W,
   parameter int ADDR_W = PIPE_ADDR_W
) (
   input  logic                  clk,
   input  logic                  reset,
`ifdef PIPE_FLUSH_EN
   input  logic                  ex_flush,
`endif
   input  logic [ID_CTRL_W-1:0]  id_ctrl,
   input  logic [ADDR_W-1:0]     id_rs_addr,
   input  logic [ADDR_W-1:0]     id_rt_addr,
   input  logic [DATA_W-1:0]     id_rd1,
   input  logic [DATA_W-1:0]     id_rd2,
   input  logic [DATA_W-1:0]     id_imm,
   output logic [ID_CTRL_W-1:0]  ex_ctrl,
   output logic [ADDR_W-1:0]     ex_rs_addr,
   output logic [ADDR_W-1:0]     ex_rt_addr,
   output logic [DATA_W-1:0]     ex_rd1,
   output logic [DATA_W-1:0]     ex_rd2,
   output logic [DATA_W-1:0]     ex_imm,
   input  logic [DATA_W-1:0]     ex_alu_out,
   output logic [MEM_CTRL_W-1:0] mem_ctrl,
   output logic [DATA_W-1:0]     mem_alu_out,
   output logic [DATA_W-1:0]     mem_rd2,
   output logic [ADDR_W-1:0]     mem_dst_addr,
   input  logic [DATA_W-1:0]     mem_data,
   output logic                  wb_reg_write,
   output logic                  wb_mem_to_reg,
   output logic                  wb_in_port,
   output logic [ADDR_W-1:0]     wb_write_addr,
   output logic [DATA_W-1:0]     wb_alu_out,
   output logic [DATA_W-1:0]     wb_mem_data
);

   localparam int IDEX_W  = 2*ADDR_W + 3*DATA_W;
   localparam int EXMEM_W = 2*DATA_W + ADDR_W;
   localparam int MEMWB_W = 3 + ADDR_W + 2*DATA_W;

   logic [ID_CTRL_W-1:0] w_id_ctrl_d;
   logic [IDEX_W-1:0]    w_idex_q;
   logic [EXMEM_W-1:0]   w_exmem_q;
   logic [MEMWB_W-1:0]   w_memwb_q;

   // Flush only kills the control bundle; reset still wins inside pipe_reg.
`ifdef PIPE_FLUSH_EN
   assign w_id_ctrl_d = ex_flush ? '0 : id_ctrl;
`else
   assign w_id_ctrl_d = id_ctrl;
`endif

   pipe_reg #(.W(ID_CTRL_W)) u_idex_ctrl (
      .clk   (clk),
      .reset (reset),
      .d     (w_id_ctrl_d),
      .q     (ex_ctrl)
   );

   pipe_reg #(.W(IDEX_W)) u_idex_data (
      .clk   (clk),
      .reset (reset),
      .d     ({id_rs_addr, id_rt_addr, id_rd1, id_rd2, id_imm}),
      .q     (w_idex_q)
   );

   assign {ex_rs_addr, ex_rt_addr, ex_rd1, ex_rd2, ex_imm} = w_idex_q;

   pipe_reg #(.W(MEM_CTRL_W)) u_exmem_ctrl (
      .clk   (clk),
      .reset (reset),
      .d     (ex_to_mem_ctrl(ex_ctrl)),
      .q     (mem_ctrl)
   );

   // rs is the destination register from here on
   pipe_reg #(.W(EXMEM_W)) u_exmem_data (
      .clk   (clk),
      .reset (reset),
      .d     ({ex_alu_out, ex_rd2, ex_rs_addr}),
      .q     (w_exmem_q)
   );

   assign {mem_alu_out, mem_rd2, mem_dst_addr} = w_exmem_q;

   pipe_reg #(.W(MEMWB_W)) u_memwb (
      .clk   (clk),
      .reset (reset),
      .d     ({mem_ctrl[MEM_REG_WRITE], mem_ctrl[MEM_MEM_TO_REG], mem_ctrl[MEM_IN_PORT],
               mem_dst_addr, mem_alu_out, mem_data}),
      .q     (w_memwb_q)
   );

   assign {wb_reg_write, wb_mem_to_reg, wb_in_port, wb_write_addr, wb_alu_out, wb_mem_data} = w_memwb_q;

endmodule

// File: tb/tb_pipe_regs_id_ex_mem_wb.sv
module tb_pipe_regs_id_ex_mem_wb;

   logic        clk = 1'b0;
   logic        reset;
   logic        ex_flush;
   logic [17:0] id_ctrl;
   logic [2:0]  id_rs_addr, id_rt_addr;
   logic [15:0] id_rd1, id_rd2, id_imm;
   logic [17:0] ex_ctrl;
   logic [2:0]  ex_rs_addr, ex_rt_addr;
   logic [15:0] ex_rd1, ex_rd2, ex_imm;
   logic [15:0] ex_alu_out;
   logic [12:0] mem_ctrl;
   logic [15:0] mem_alu_out, mem_rd2;
   logic [2:0]  mem_dst_addr;
   logic [15:0] mem_data;
   logic        wb_reg_write, wb_mem_to_reg, wb_in_port;
   logic [2:0]  wb_write_addr;
   logic [15:0] wb_alu_out, wb_mem_data;

   pipe_regs_id_ex_mem_wb dut (
      .clk           (clk),
      .reset         (reset),
`ifdef PIPE_FLUSH_EN
      .ex_flush      (ex_flush),
`endif
      .id_ctrl       (id_ctrl),
      .id_rs_addr    (id_rs_addr),
      .id_rt_addr    (id_rt_addr),
      .id_rd1        (id_rd1),
      .id_rd2        (id_rd2),
      .id_imm        (id_imm),
      .ex_ctrl       (ex_ctrl),
      .ex_rs_addr    (ex_rs_addr),
      .ex_rt_addr    (ex_rt_addr),
      .ex_rd1        (ex_rd1),
      .ex_rd2        (ex_rd2),
      .ex_imm        (ex_imm),
      .ex_alu_out    (ex_alu_out),
      .mem_ctrl      (mem_ctrl),
      .mem_alu_out   (mem_alu_out),
      .mem_rd2       (mem_rd2),
      .mem_dst_addr  (mem_dst_addr),
      .mem_data      (mem_data),
      .wb_reg_write  (wb_reg_write),
      .wb_mem_to_reg (wb_mem_to_reg),
      .wb_in_port    (wb_in_port),
      .wb_write_addr (wb_write_addr),
      .wb_alu_out    (wb_alu_out),
      .wb_mem_data   (wb_mem_data)
   );

   always #5 clk = ~clk;

   typedef struct {
      int          due;
      logic [17:0] ctrl;
      logic [2:0]  a0;
      logic [2:0]  a1;
      logic [15:0] d0;
      logic [15:0] d1;
      logic [15:0] d2;
   } exp_t;

   exp_t q_ex[$], q_mem[$], q_wb[$], q_malu[$], q_walu[$], q_wmd[$];

   int checks   = 0;
   int failures = 0;
   int cyc      = 0;

   // decode bundle minus alu_op[17:15], alu_src[10], imm[1]
   function automatic logic [12:0] mem_view(input logic [17:0] c);
      return {c[14:12], c[11], c[9:2], c[0]};
   endfunction

   task automatic chk(input string tag, input logic [17:0] obs, input logic [17:0] exp);
      checks++;
      assert (obs === exp)
      else begin
         failures++;
         $error("FAIL %s cycle=%0d observed=%0h expected=%0h", tag, cyc, obs, exp);
      end
   endtask

   task automatic zero_pending(inout exp_t q[$]);
      for (int i = 0; i < q.size(); i++) begin
         exp_t z;
         z = '{due: q[i].due, ctrl: '0, a0: '0, a1: '0, d0: '0, d1: '0, d2: '0};
         q[i] = z;
      end
   endtask

   // Push expectations for the inputs currently driven, clock once, then check
   // every entry that has come due.
   task automatic step();
      exp_t e;
      logic [17:0] c_cap;
      c_cap = id_ctrl;
`ifdef PIPE_FLUSH_EN
      if (ex_flush) c_cap = '0;
`endif
      if (reset) begin
         zero_pending(q_ex);  zero_pending(q_mem);  zero_pending(q_wb);
         zero_pending(q_malu); zero_pending(q_walu); zero_pending(q_wmd);
      end
      e = '{due: cyc+1, ctrl: c_cap, a0: id_rs_addr, a1: id_rt_addr, d0: id_rd1, d1: id_rd2, d2: id_imm};
      if (reset) e = '{due: cyc+1, ctrl: '0, a0: '0, a1: '0, d0: '0, d1: '0, d2: '0};
      q_ex.push_back(e);
      e = '{due: cyc+2, ctrl: {5'b0, mem_view(c_cap)}, a0: id_rs_addr, a1: '0, d0: '0, d1: id_rd2, d2: '0};
      if (reset) e = '{due: cyc+2, ctrl: '0, a0: '0, a1: '0, d0: '0, d1: '0, d2: '0};
      q_mem.push_back(e);
      e = '{due: cyc+3, ctrl: {15'b0, c_cap[11], c_cap[8], c_cap[5]}, a0: id_rs_addr, a1: '0, d0: '0, d1: '0, d2: '0};
      if (reset) e = '{due: cyc+3, ctrl: '0, a0: '0, a1: '0, d0: '0, d1: '0, d2: '0};
      q_wb.push_back(e);
      e = '{due: cyc+1, ctrl: '0, a0: '0, a1: '0, d0: reset ? 16'h0 : ex_alu_out, d1: '0, d2: '0};
      q_malu.push_back(e);
      e.due = cyc+2;
      q_walu.push_back(e);
      e = '{due: cyc+1, ctrl: '0, a0: '0, a1: '0, d0: reset ? 16'h0 : mem_data, d1: '0, d2: '0};
      q_wmd.push_back(e);

      @(posedge clk);
      #1;
      cyc++;

      if (q_ex.size() > 0 && q_ex[0].due == cyc) begin
         e = q_ex.pop_front();
         chk("ex_ctrl", ex_ctrl, e.ctrl);
         chk("ex_rs_addr", {15'b0, ex_rs_addr}, {15'b0, e.a0});
         chk("ex_rt_addr", {15'b0, ex_rt_addr}, {15'b0, e.a1});
         chk("ex_rd1", {2'b0, ex_rd1}, {2'b0, e.d0});
         chk("ex_rd2", {2'b0, ex_rd2}, {2'b0, e.d1});
         chk("ex_imm", {2'b0, ex_imm}, {2'b0, e.d2});
      end
      if (q_mem.size() > 0 && q_mem[0].due == cyc) begin
         e = q_mem.pop_front();
         chk("mem_ctrl", {5'b0, mem_ctrl}, e.ctrl);
         chk("mem_dst_addr", {15'b0, mem_dst_addr}, {15'b0, e.a0});
         chk("mem_rd2", {2'b0, mem_rd2}, {2'b0, e.d1});
      end
      if (q_wb.size() > 0 && q_wb[0].due == cyc) begin
         e = q_wb.pop_front();
         chk("wb_reg_write", {17'b0, wb_reg_write}, {17'b0, e.ctrl[2]});
         chk("wb_mem_to_reg", {17'b0, wb_mem_to_reg}, {17'b0, e.ctrl[1]});
         chk("wb_in_port", {17'b0, wb_in_port}, {17'b0, e.ctrl[0]});
         chk("wb_write_addr", {15'b0, wb_write_addr}, {15'b0, e.a0});
      end
      if (q_malu.size() > 0 && q_malu[0].due == cyc) begin
         e = q_malu.pop_front();
         chk("mem_alu_out", {2'b0, mem_alu_out}, {2'b0, e.d0});
      end
      if (q_walu.size() > 0 && q_walu[0].due == cyc) begin
         e = q_walu.pop_front();
         chk("wb_alu_out", {2'b0, wb_alu_out}, {2'b0, e.d0});
      end
      if (q_wmd.size() > 0 && q_wmd[0].due == cyc) begin
         e = q_wmd.pop_front();
         chk("wb_mem_data", {2'b0, wb_mem_data}, {2'b0, e.d0});
      end
   endtask

   task automatic idle();
      id_ctrl = '0; id_rs_addr = '0; id_rt_addr = '0;
      id_rd1 = '0; id_rd2 = '0; id_imm = '0;
      ex_alu_out = '0; mem_data = '0; ex_flush = 1'b0;
   endtask

   initial begin
      idle();
      reset = 1'b1;
      step(); step();
      reset = 1'b0;
      repeat (3) step();

      // all-ones control with rd1/rs through every stage
      id_ctrl = 18'h3FFFF; id_rd1 = 16'h1234; id_rs_addr = 3'd5;
      step();
      idle();
      repeat (3) step();

      // store data then ALU result on the following cycle
      id_rd2 = 16'h00AA;
      step();
      idle();
      ex_alu_out = 16'hBEEF;
      step();
      idle();
      repeat (2) step();

      // load: mem_to_register decoded, memory data arrives two cycles later
      id_ctrl = 18'h00900; id_rs_addr = 3'd3;
      step();
      idle();
      step();
      mem_data = 16'hCAFE;
      step();
      idle();
      repeat (2) step();

      // back-to-back distinct values
      for (int i = 1; i <= 3; i++) begin
         id_rd1 = 16'(i); id_rd2 = 16'(i); id_imm = 16'(i);
         id_rs_addr = 3'(i); id_rt_addr = 3'(7 - i);
         id_ctrl = 18'(i << 11);
         ex_alu_out = 16'(i); mem_data = 16'(i);
         step();
      end
      idle();
      repeat (3) step();

      // random traffic
      for (int i = 0; i < 20; i++) begin
         id_ctrl = 18'($urandom); id_rs_addr = 3'($urandom); id_rt_addr = 3'($urandom);
         id_rd1 = 16'($urandom); id_rd2 = 16'($urandom); id_imm = 16'($urandom);
         ex_alu_out = 16'($urandom); mem_data = 16'($urandom);
         step();
      end

      // reset mid-stream with nonzero inputs: everything in flight discarded
      reset = 1'b1;
      step();
      reset = 1'b0;
      for (int i = 0; i < 4; i++) begin
         id_ctrl = 18'($urandom); id_rs_addr = 3'($urandom);
         id_rd2 = 16'($urandom); ex_alu_out = 16'($urandom); mem_data = 16'($urandom);
         step();
      end
      idle();
      repeat (3) step();

`ifdef PIPE_FLUSH_EN
      ex_flush = 1'b1; id_ctrl = 18'h3FFFF; id_rd1 = 16'h5555; id_rs_addr = 3'd6;
      step();
      ex_flush = 1'b0;
      step();
      ex_flush = 1'b1; reset = 1'b1;
      step();
      reset = 1'b0;
      idle();
      repeat (3) step();
`endif

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
